// File: rtl/ball_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ball_pkg
//  Description : Shared types and default geometry for the ball motion engine.
//                Holds the FSM state encoding, screen and paddle constants,
//                and the signed velocity type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ball_pkg;

    // Datapath widths
    localparam int c_POS_W     = 10;
    localparam int c_VEL_W     = 4;

    // Screen geometry
    localparam int c_SCREEN_W  = 640;
    localparam int c_SCREEN_H  = 480;
    localparam int c_BALL_SIZE = 8;

    // Paddle geometry
    localparam int c_PADDLE_Y  = 460;
    localparam int c_PADDLE_W  = 64;

    // Launch position and velocity after reset or re-arm
    localparam int c_START_X   = 316;
    localparam int c_START_Y   = 440;
    localparam int c_VX0       = 2;
    localparam int c_VY0       = -2;

    // Signed per-frame velocity
    typedef logic signed [c_VEL_W-1:0] vel_t;

    // Engine states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LOST  = 2'd3
    } state_t;

endpackage : ball_pkg
`default_nettype wire

// File: rtl/ball_axis_step.sv
`default_nettype none
// ============================================================================
//  Module      : ball_axis_step
//  Description : Single-axis position integrator. Adds the signed velocity
//                to the position on each step, clamps at the LO/HI limits and
//                negates the velocity on a reflecting limit. An override lets
//                the owner force a position and negate the velocity (paddle).
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_axis_step #(
    parameter int POS_W      = 10,
    parameter int VEL_W      = 4,
    parameter int LO         = 0,
    parameter int HI         = 632,
    parameter bit HI_REFLECT = 1'b1,
    parameter int RESET_POS  = 316,
    parameter int RESET_VEL  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_rearm,
    input  logic                    i_step,
    input  logic                    i_ovr,
    input  logic [POS_W-1:0]        i_ovr_pos,
    output logic [POS_W-1:0]        o_pos,
    output logic signed [POS_W+1:0] o_nxt,
    output logic                    o_refl
);

    // Two guard bits keep the sum free of wrap in both directions
    localparam int c_NW = POS_W + 2;

    localparam logic signed [c_NW-1:0]  c_LO_S    = c_NW'(LO);
    localparam logic signed [c_NW-1:0]  c_HI_S    = c_NW'(HI);
    localparam logic [POS_W-1:0]        c_LO_POS  = POS_W'(LO);
    localparam logic [POS_W-1:0]        c_HI_POS  = POS_W'(HI);
    localparam logic [POS_W-1:0]        c_RST_POS = POS_W'(RESET_POS);
    localparam logic [VEL_W-1:0]        c_RST_VEL = VEL_W'(RESET_VEL);

    logic [POS_W-1:0]        r_pos;
    logic signed [VEL_W-1:0] r_vel;

    logic signed [c_NW-1:0]  w_pos_s;
    logic signed [c_NW-1:0]  w_vel_s;
    logic signed [c_NW-1:0]  w_nxt;
    logic                    w_hit_lo;
    logic                    w_hit_hi;

    assign w_pos_s  = {2'b00, r_pos};
    assign w_vel_s  = {{(c_NW-VEL_W){r_vel[VEL_W-1]}}, r_vel};
    assign w_nxt    = w_pos_s + w_vel_s;
    assign w_hit_lo = (w_nxt < c_LO_S);
    assign w_hit_hi = (w_nxt > c_HI_S);

    assign o_pos  = r_pos;
    assign o_nxt  = w_nxt;
    assign o_refl = w_hit_lo || (w_hit_hi && HI_REFLECT);

    // Integrate on step; limits clamp, reflecting limits also flip the sign
    always_ff @(posedge clk) begin
        if (!reset_n || i_rearm) begin
            r_pos <= c_RST_POS;
            r_vel <= c_RST_VEL;
        end else if (i_step) begin
            if (i_ovr) begin
                r_pos <= i_ovr_pos;
                r_vel <= -r_vel;
            end else if (w_hit_lo) begin
                r_pos <= c_LO_POS;
                r_vel <= -r_vel;
            end else if (w_hit_hi) begin
                r_pos <= c_HI_POS;
                if (HI_REFLECT) begin
                    r_vel <= -r_vel;
                end
            end else begin
                r_pos <= w_nxt[POS_W-1:0];
            end
        end
    end

endmodule : ball_axis_step
`default_nettype wire

// File: rtl/ball_motion_engine.sv
`default_nettype none
// ============================================================================
//  Module      : ball_motion_engine
//  Description : Per-frame ball mover gated by the Nios enable PIO. Walls
//                reflect the ball, the paddle reflects it while it descends
//                across the paddle line over the paddle, and passing the
//                floor drops the engine into LOST until enable is released.
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_motion_engine
    import ball_pkg::*;
#(
    parameter int SCREEN_W  = c_SCREEN_W,
    parameter int SCREEN_H  = c_SCREEN_H,
    parameter int BALL_SIZE = c_BALL_SIZE,
    parameter int PADDLE_Y  = c_PADDLE_Y,
    parameter int PADDLE_W  = c_PADDLE_W,
    parameter int START_X   = c_START_X,
    parameter int START_Y   = c_START_Y,
    parameter int VX0       = c_VX0,
    parameter int VY0       = c_VY0,
    parameter int POS_W     = c_POS_W,
    parameter int VEL_W     = c_VEL_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             frame_tick,
    input  logic [POS_W-1:0] paddle_x,
    output logic [POS_W-1:0] ball_x,
    output logic [POS_W-1:0] ball_y,
    output logic             moving,
    output logic             bounce,
    output logic             lost
);

    // Axis sums are POS_W+2 signed; one more bit lets the paddle tests add
    // offsets to them without any wrap
    localparam int c_NW = POS_W + 2;
    localparam int c_CW = POS_W + 3;

    localparam logic signed [c_CW-1:0] c_BS    = c_CW'(BALL_SIZE);
    localparam logic signed [c_CW-1:0] c_PY    = c_CW'(PADDLE_Y);
    localparam logic signed [c_CW-1:0] c_PW    = c_CW'(PADDLE_W);
    localparam logic signed [c_CW-1:0] c_FLOOR = c_CW'(SCREEN_H - BALL_SIZE);
    localparam logic [POS_W-1:0]       c_REST  = POS_W'(PADDLE_Y - BALL_SIZE);

    state_t r_state;

    logic                   w_tick;
    logic                   w_step;
    logic                   w_rearm;
    logic signed [c_NW-1:0] w_x_nxt;
    logic signed [c_NW-1:0] w_y_nxt;
    logic                   w_x_refl;
    logic                   w_y_refl;
    logic signed [c_CW-1:0] w_nx;
    logic signed [c_CW-1:0] w_ny;
    logic signed [c_CW-1:0] w_y;
    logic signed [c_CW-1:0] w_px;
    logic                   w_desc;
    logic                   w_above;
    logic                   w_cross;
    logic                   w_overlap;
    logic                   w_paddle;
    logic                   w_floor;

    // A tick only counts when enable is sampled high on the same cycle
    assign w_tick  = frame_tick && en;
    assign w_step  = (r_state == ST_MOVE) && w_tick;
    assign w_rearm = (r_state == ST_IDLE) || ((r_state == ST_LOST) && !en);

    ball_axis_step #(
        .POS_W      (POS_W),
        .VEL_W      (VEL_W),
        .LO         (0),
        .HI         (SCREEN_W - BALL_SIZE),
        .HI_REFLECT (1'b1),
        .RESET_POS  (START_X),
        .RESET_VEL  (VX0)
    ) u_axis_x (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_rearm    (w_rearm),
        .i_step     (w_step),
        .i_ovr      (1'b0),
        .i_ovr_pos  ({POS_W{1'b0}}),
        .o_pos      (ball_x),
        .o_nxt      (w_x_nxt),
        .o_refl     (w_x_refl)
    );

    // The floor clamps but does not reflect; losing the ball is decided here
    ball_axis_step #(
        .POS_W      (POS_W),
        .VEL_W      (VEL_W),
        .LO         (0),
        .HI         (SCREEN_H - BALL_SIZE),
        .HI_REFLECT (1'b0),
        .RESET_POS  (START_Y),
        .RESET_VEL  (VY0)
    ) u_axis_y (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_rearm    (w_rearm),
        .i_step     (w_step),
        .i_ovr      (w_paddle),
        .i_ovr_pos  (c_REST),
        .o_pos      (ball_y),
        .o_nxt      (w_y_nxt),
        .o_refl     (w_y_refl)
    );

    assign w_nx = {w_x_nxt[c_NW-1], w_x_nxt};
    assign w_ny = {w_y_nxt[c_NW-1], w_y_nxt};
    assign w_y  = {3'b000, ball_y};
    assign w_px = {3'b000, paddle_x};

    // Descending is equivalent to the next y lying below the current y
    assign w_desc    = (w_ny > w_y);
    assign w_above   = ((w_y + c_BS) <= c_PY);
    assign w_cross   = ((w_ny + c_BS) > c_PY);
    assign w_overlap = ((w_nx + c_BS) > w_px) && (w_nx < (w_px + c_PW));
    assign w_paddle  = w_desc && w_above && w_cross && w_overlap;
    assign w_floor   = (w_ny > c_FLOOR) && !w_paddle;

    // Engine FSM with registered status outputs and one-cycle event pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            moving  <= 1'b0;
            bounce  <= 1'b0;
            lost    <= 1'b0;
        end else begin
            bounce <= 1'b0;
            lost   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= ST_MOVE;
                        moving  <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (!en) begin
                        r_state <= ST_PAUSE;
                        moving  <= 1'b0;
                    end else if (frame_tick) begin
                        bounce <= w_x_refl || w_y_refl || w_paddle;
                        if (w_floor) begin
                            r_state <= ST_LOST;
                            moving  <= 1'b0;
                            lost    <= 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (en) begin
                        r_state <= ST_MOVE;
                        moving  <= 1'b1;
                    end
                end
                ST_LOST: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    moving  <= 1'b0;
                end
            endcase
        end
    end

endmodule : ball_motion_engine
`default_nettype wire

// File: tb/tb_ball_motion_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_motion_engine
//  Description : Self-checking bench for ball_motion_engine. A frame-level
//                reference model tracks position, velocity and engine mode
//                from the behavioural rules; directed openers are followed by
//                randomized enable, tick, paddle and reset stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_motion_engine;

    localparam int SW = 640;
    localparam int SH = 480;
    localparam int BS = 8;
    localparam int PY = 460;
    localparam int PW = 64;
    localparam int SX = 316;
    localparam int SY = 440;

    localparam int M_IDLE  = 0;
    localparam int M_MOVE  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LOST  = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       frame_tick;
    logic [9:0] paddle_x;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       moving;
    logic       bounce;
    logic       lost;

    int n_checks = 0;
    int n_errors = 0;

    int m_mode;
    int m_x;
    int m_y;
    int m_vx;
    int m_vy;
    bit m_bounce;
    bit m_lost;

    bit prev_tick;
    bit en_lvl;

    always #5 clk = ~clk;

    ball_motion_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .frame_tick (frame_tick),
        .paddle_x   (paddle_x),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .moving     (moving),
        .bounce     (bounce),
        .lost       (lost)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_rearm();
        m_mode = M_IDLE;
        m_x    = SX;
        m_y    = SY;
        m_vx   = 2;
        m_vy   = -2;
    endtask

    // One frame of motion from the geometric rules
    task automatic model_frame(input int px);
        int nx;
        int ny;
        bit on_paddle;
        nx = m_x + m_vx;
        ny = m_y + m_vy;
        on_paddle = (m_vy > 0) && (m_y + BS <= PY) && (ny + BS > PY)
                    && (nx + BS > px) && (nx < px + PW);
        if (nx < 0) begin
            m_x = 0; m_vx = -m_vx; m_bounce = 1'b1;
        end else if (nx > SW - BS) begin
            m_x = SW - BS; m_vx = -m_vx; m_bounce = 1'b1;
        end else begin
            m_x = nx;
        end
        if (ny < 0) begin
            m_y = 0; m_vy = -m_vy; m_bounce = 1'b1;
        end else if (on_paddle) begin
            m_y = PY - BS; m_vy = -m_vy; m_bounce = 1'b1;
        end else if (ny > SH - BS) begin
            m_y = SH - BS; m_mode = M_LOST; m_lost = 1'b1;
        end else begin
            m_y = ny;
        end
    endtask

    task automatic model_clock(input bit r, input bit e, input bit t, input int px);
        m_bounce = 1'b0;
        m_lost   = 1'b0;
        if (!r) begin
            model_rearm();
        end else begin
            case (m_mode)
                M_IDLE:  if (t && e) m_mode = M_MOVE;
                M_MOVE:  if (!e) m_mode = M_PAUSE; else if (t) model_frame(px);
                M_PAUSE: if (e) m_mode = M_MOVE;
                default: if (!e) model_rearm();
            endcase
        end
    endtask

    // Drive on the falling edge, advance the model at the rising edge, compare after it
    task automatic drive_cycle(input bit r, input bit e, input bit t, input int px);
        @(negedge clk);
        reset_n    = r;
        en         = e;
        frame_tick = t;
        paddle_x   = 10'(px);
        @(posedge clk);
        model_clock(r, e, t, px);
        #1;
        check_val("ball_x", int'(ball_x), m_x);
        check_val("ball_y", int'(ball_y), m_y);
        check_val("moving", int'(moving), (m_mode == M_MOVE) ? 1 : 0);
        check_val("bounce", int'(bounce), int'(m_bounce));
        check_val("lost",   int'(lost),   int'(m_lost));
    endtask

    initial begin
        reset_n    = 1'b0;
        en         = 1'b0;
        frame_tick = 1'b0;
        paddle_x   = 10'd0;
        model_rearm();
        m_bounce   = 1'b0;
        m_lost     = 1'b0;

        // Reset state
        drive_cycle(1'b0, 1'b0, 1'b0, 300);
        drive_cycle(1'b0, 1'b0, 1'b0, 300);
        check_val("rst_x", int'(ball_x), 316);
        check_val("rst_y", int'(ball_y), 440);
        check_val("rst_moving", int'(moving), 0);

        // First tick arms without moving, second tick moves
        drive_cycle(1'b1, 1'b1, 1'b1, 300);
        check_val("arm_x", int'(ball_x), 316);
        check_val("arm_y", int'(ball_y), 440);
        check_val("arm_moving", int'(moving), 1);
        drive_cycle(1'b1, 1'b1, 1'b0, 300);
        drive_cycle(1'b1, 1'b1, 1'b1, 300);
        check_val("step_x", int'(ball_x), 318);
        check_val("step_y", int'(ball_y), 438);

        // Enable low freezes across ticks; resume waits for the next tick
        drive_cycle(1'b1, 1'b0, 1'b0, 300);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 1'b0, 1'b1, 300);
            drive_cycle(1'b1, 1'b0, 1'b0, 300);
        end
        check_val("pause_x", int'(ball_x), 318);
        check_val("pause_y", int'(ball_y), 438);
        drive_cycle(1'b1, 1'b1, 1'b1, 300);
        check_val("resume_hold_x", int'(ball_x), 318);
        drive_cycle(1'b1, 1'b1, 1'b0, 300);
        drive_cycle(1'b1, 1'b1, 1'b1, 300);
        check_val("resume_x", int'(ball_x), 320);
        check_val("resume_y", int'(ball_y), 436);

        // Reset coincident with a tick while moving
        drive_cycle(1'b0, 1'b1, 1'b1, 300);
        check_val("rsttick_x", int'(ball_x), 316);
        check_val("rsttick_y", int'(ball_y), 440);
        check_val("rsttick_moving", int'(moving), 0);
        check_val("rsttick_bounce", int'(bounce), 0);
        drive_cycle(1'b1, 1'b1, 1'b0, 300);

        // Randomized play: paddle mostly tracks the ball, occasionally wanders
        prev_tick = 1'b0;
        en_lvl    = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            bit r;
            bit t;
            int px;
            r = ($urandom_range(0, 2999) != 0);
            if (en_lvl) begin
                if ($urandom_range(0, 59) == 0) en_lvl = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                en_lvl = 1'b1;
            end
            t = !prev_tick && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) != 0) begin
                px = m_x - int'($urandom_range(0, 60));
                if (px < 0) px = 0;
            end else begin
                px = int'($urandom_range(0, 639));
            end
            prev_tick = t;
            drive_cycle(r, en_lvl, t, px);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ball_motion_engine
`default_nettype wire
